// File: rtl/mult_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_sched_if
// Description : Requester, datapath-control and response signals of the
//               add/shift multiplier scheduler, with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_sched_if;
    logic req0_valid;
    logic req1_valid;
    logic req0_ready;
    logic req1_ready;
    logic sel;
    logic mult;
    logic cleara;
    logic loadb;
    logic add;
    logic sub;
    logic Shift_En;
    logic resp_valid;
    logic resp_id;
    logic resp_ready;
    logic busy;

    modport slave (
        input  req0_valid, req1_valid, mult, resp_ready,
        output req0_ready, req1_ready, sel, cleara, loadb, add, sub,
               Shift_En, resp_valid, resp_id, busy
    );

    modport master (
        output req0_valid, req1_valid, mult, resp_ready,
        input  req0_ready, req1_ready, sel, cleara, loadb, add, sub,
               Shift_En, resp_valid, resp_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/mult_sched.sv
`default_nettype none
// ============================================================================
// Module      : mult_sched
// Description : Two-requester round-robin scheduler sequencing a signed
//               add/shift multiplier datapath (Booth-style final subtract).
//               Optional MULT_SCHED_BACK2BACK_EN: re-arbitrate in RESP so the
//               next job loads with no idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_sched #(
    parameter int WIDTH = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    mult_sched_if.slave bus
);

    localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ADD    = 3'd2,
        S_SHIFT  = 3'd3,
        S_SUB    = 3'd4,
        S_SHIFTL = 3'd5,
        S_RESP   = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_sel;
    logic                 r_ptr;

    logic w_last;
    logic w_gnt_id;
    logic w_arb_en;
    logic w_rdy0;
    logic w_rdy1;
    logic w_accept;
    logic w_cleara;
    logic w_loadb;
    logic w_add;
    logic w_sub;
    logic w_shift;
    logic w_resp_valid;
    logic w_resp_id;

    // In RESP the job being answered is the one last served, ahead of r_ptr.
    assign w_last   = (r_state == S_RESP) ? r_sel : r_ptr;
    assign w_gnt_id = (bus.req0_valid && bus.req1_valid) ? ~w_last : bus.req1_valid;

`ifdef MULT_SCHED_BACK2BACK_EN
    assign w_arb_en = Reset && ((r_state == S_IDLE) ||
                                ((r_state == S_RESP) && bus.resp_ready));
`else
    assign w_arb_en = Reset && (r_state == S_IDLE);
`endif

    assign w_rdy0   = w_arb_en && bus.req0_valid && !w_gnt_id;
    assign w_rdy1   = w_arb_en && bus.req1_valid &&  w_gnt_id;
    assign w_accept = w_rdy0 || w_rdy1;

    always_comb begin
        w_next       = r_state;
        w_cleara     = 1'b0;
        w_loadb      = 1'b0;
        w_add        = 1'b0;
        w_sub        = 1'b0;
        w_shift      = 1'b0;
        w_resp_valid = 1'b0;
        w_resp_id    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_cleara = 1'b1;
                w_loadb  = 1'b1;
                w_next   = S_ADD;
            end
            S_ADD: begin
                w_add  = bus.mult;
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                w_next  = (r_cnt == c_last) ? S_SUB : S_ADD;
            end
            S_SUB: begin
                w_sub  = bus.mult;
                w_next = S_SHIFTL;
            end
            S_SHIFTL: begin
                w_shift = 1'b1;
                w_next  = S_RESP;
            end
            S_RESP: begin
                w_resp_valid = 1'b1;
                w_resp_id    = r_sel;
                if (bus.resp_ready) w_next = w_accept ? S_LOAD : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sel   <= 1'b0;
            r_ptr   <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == S_LOAD)
                r_cnt <= '0;
            else if (r_state == S_SHIFT)
                r_cnt <= r_cnt + 1'b1;
            if (w_accept)
                r_sel <= w_gnt_id;
            if ((r_state == S_RESP) && bus.resp_ready)
                r_ptr <= r_sel;
        end
    end

    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.sel        = r_sel;
    assign bus.cleara     = w_cleara;
    assign bus.loadb      = w_loadb;
    assign bus.add        = w_add;
    assign bus.sub        = w_sub;
    assign bus.Shift_En   = w_shift;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_id    = w_resp_id;
    assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_sched
// Description : Directed self-checking bench for mult_sched (WIDTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_sched;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  r_breg = '0;
    logic [10:0] w_obs;
    int          n_assert = 0;
    int          n_fail   = 0;

    mult_sched_if bus ();

    mult_sched #(.WIDTH(8)) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Datapath stand-in: multiplier register loaded from the selected requester.
    always @(posedge Clk) begin
        if (bus.loadb)
            r_breg <= bus.sel ? b1 : b0;
        else if (bus.Shift_En)
            r_breg <= r_breg >> 1;
    end
    assign bus.mult = r_breg[0];

    // {req0_ready, req1_ready, sel, cleara, loadb, add, sub, Shift_En, resp_valid, resp_id, busy}
    assign w_obs = {bus.req0_ready, bus.req1_ready, bus.sel, bus.cleara, bus.loadb,
                    bus.add, bus.sub, bus.Shift_En, bus.resp_valid, bus.resp_id, bus.busy};

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Walks one job from its accept edge; stop_at > 0 ends early after that cycle.
    task automatic run_op(input logic id, input logic [7:0] b, input int exp_adds,
                          input bit drop, input int stop_at);
        int n_add = 0;
        int n_sh  = 0;
        logic cl, lb, ad, sb, sh;
        @(posedge Clk);
        for (int j = 1; j <= 17; j++) begin
            @(negedge Clk);
            if (drop && j == 1) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            #1;
            cl = (j == 1); lb = (j == 1);
            ad = 1'b0; sb = 1'b0; sh = 1'b0;
            if (j >= 2 && j <= 15 && (j % 2 == 0)) ad = b[j/2 - 1];
            if (j >= 3 && j <= 15 && (j % 2 == 1)) sh = 1'b1;
            if (j == 16) sb = b[7];
            if (j == 17) sh = 1'b1;
            check($sformatf("op%0d_cyc%0d", id, j), 32'(w_obs),
                  32'({2'b00, id, cl, lb, ad, sb, sh, 1'b0, 1'b0, 1'b1}));
            n_add += int'(bus.add);
            n_sh  += int'(bus.Shift_En);
            if (j == stop_at) return;
        end
        @(negedge Clk); #1;
        check($sformatf("op%0d_resp_valid", id), 32'(bus.resp_valid), 32'd1);
        check($sformatf("op%0d_resp_id", id), 32'(bus.resp_id), 32'(id));
        check($sformatf("op%0d_resp_strobes", id),
              32'({bus.cleara, bus.loadb, bus.add, bus.sub, bus.Shift_En, bus.busy}), 32'b000001);
        check($sformatf("op%0d_add_count", id), 32'(n_add), 32'(exp_adds));
        check($sformatf("op%0d_shift_count", id), 32'(n_sh), 32'd8);
    endtask

    initial begin
        Reset          = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b1;
        b0             = 8'h03;
        b1             = 8'h00;

        // Reset: every output low even with a valid request pending.
        @(negedge Clk); #1;
        check("reset_outputs", 32'(w_obs), 32'd0);
        @(negedge Clk); #1;
        check("reset_outputs_2", 32'(w_obs), 32'd0);

        // B = 0x03 from req0: ready on first cycle after release.
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("a_ready0", 32'(w_obs), 32'b10000000000);
        run_op(1'b0, 8'h03, 2, 1'b1, 0);
        @(negedge Clk); #1;
        check("a_idle", 32'(w_obs), 32'd0);

        // Reset in the third SHIFT; pointer must return to favour req0.
        bus.req0_valid = 1'b1;
        b0             = 8'h55;
        #1;
        check("c_ready0", 32'(w_obs), 32'b10000000000);
        run_op(1'b0, 8'h55, 0, 1'b1, 7);
        Reset = 1'b0;
        #1;
        check("c_reset_midop", 32'(w_obs), 32'd0);

        // Both requesters held: grants alternate 0, 1, 0.
        @(negedge Clk);
        b0             = 8'h0F;
        b1             = 8'hF0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        Reset          = 1'b1;
        #1;
        check("d_tie_grant0", 32'(w_obs), 32'b10000000000);
        run_op(1'b0, 8'h0F, 4, 1'b0, 0);
`ifdef MULT_SCHED_BACK2BACK_EN
        check("d_b2b_grant1", 32'(w_obs), 32'b01000000101);
`else
        @(negedge Clk); #1;
        check("d_idle_grant1", 32'(w_obs), 32'b01000000000);
`endif
        run_op(1'b1, 8'hF0, 3, 1'b0, 0);
`ifdef MULT_SCHED_BACK2BACK_EN
        check("d_b2b_grant0", 32'(w_obs), 32'b10100000111);
`else
        @(negedge Clk); #1;
        check("d_idle_grant0", 32'(w_obs), 32'b10100000000);
`endif
        run_op(1'b0, 8'h0F, 4, 1'b1, 0);
        @(negedge Clk); #1;
        check("d_idle_end", 32'(w_obs), 32'd0);

        // B = 0x80 from req1 with resp_ready held low in RESP.
        bus.req1_valid = 1'b1;
        bus.resp_ready = 1'b0;
        b1             = 8'h80;
        #1;
        check("b_ready1", 32'(w_obs), 32'b01000000000);
        run_op(1'b1, 8'h80, 0, 1'b1, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk); #1;
            check($sformatf("b_resp_hold%0d", k), 32'(w_obs), 32'b00100000111);
        end
        bus.resp_ready = 1'b1;
        #1;
        check("b_resp_rise", 32'(w_obs), 32'b00100000111);
        @(negedge Clk); #1;
        check("b_exit_idle", 32'(w_obs), 32'b00100000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
